serial_sub: RTL

SERIAL_SUB -- requirements
Module: serial_sub

---
 rtl/serial_sub.sv | 105 ++++++++++
 1 files changed

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// Latency: start accepted at edge E0 -> done_o high in the cycle after edge E0+WIDTH.
// Backpressure: none; start_i is ignored outside IDLE, so callers space starts WIDTH+2 cycles.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             borrow_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             br;
  logic [CW-1:0]    cnt;

  logic bit_d;
  logic br_nxt;
  logic last_bit;

  assign bit_d    = a_sh[0] ^ b_sh[0] ^ br;
  assign br_nxt   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
  assign last_bit = (cnt == LAST_CNT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state == SHIFT);
    done_o = (state == DONE);
  end

  // Operands shift right so bit 0 is always the bit under processing;
  // result bits enter at the MSB so the word is aligned after WIDTH shifts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      diff_o   <= '0;
      borrow_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            a_sh <= a_i;
            b_sh <= b_i;
            br   <= borrow_i;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= {bit_d, res_sh[WIDTH-1:1]};
          br     <= br_nxt;
          if (last_bit) begin
            diff_o   <= {bit_d, res_sh[WIDTH-1:1]};
            borrow_o <= br_nxt;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
